inst_rom_loader: RTL and testbench

- Responder end of the core's instruction-fetch interface: chip enable, 32-bit byte address in, 32-bit instruction out.
- Holds a word-addressed instruction store that a host fills through a valid/ready download port before the core runs.
- A small FSM sequences the block through IDLE, LOAD and RUN.
  - It tells the core when fetch data is meaningful.
  - It holds the core off while the store is being written.

---
 rtl/inst_rom_loader_pkg.sv | 24 ++
 rtl/inst_rom_loader_if.sv | 35 +++
 rtl/inst_rom_loader_array.sv | 28 ++
 rtl/inst_rom_loader.sv | 114 +++++++++++
 tb/tb_inst_rom_loader.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the instruction ROM loader slice.
//   - Bus widths and the NOP encoding used whenever a fetch is not served.
//   - Loader FSM state encoding, which the top also exports as a debug port.
//   - Small address helper used by the fetch path.
package inst_rom_loader_pkg;

  localparam int REG_BUS_W  = 32;
  localparam int INST_BUS_W = 32;

  localparam logic [REG_BUS_W-1:0]  ZERO_WORD = 32'h0000_0000;
  localparam logic [INST_BUS_W-1:0] NOP_INST  = 32'h0000_0000;

  typedef enum logic [1:0] {
    LDR_IDLE = 2'd0,
    LDR_LOAD = 2'd1,
    LDR_RUN  = 2'd2
  } ldr_state_t;

  // A fetch address is usable only when it is word aligned.
  function automatic logic addr_misaligned(input logic [31:0] a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/inst_rom_loader_if.sv
// Fetch and download bundle between the loader and its two peers.
//   Fetch side : ce, addr (from core) -> inst, hold (to core).
//   Load side  : load_start, load_valid, load_data, load_last (from host)
//                -> load_ready (to host).
//   Status     : word_count, fault (to host).
// Handshake: a download word transfers on every rising clock edge where
// load_valid and load_ready are both high. load_data/load_last are only
// meaningful while load_valid is high; the host keeps them stable until
// the transfer happens. load_ready does not depend on load_valid.
// Modports: slave = loader side, master = core/host side.
interface inst_rom_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  ce;
  logic [31:0]           addr;
  logic [31:0]           inst;
  logic                  hold;
  logic                  load_start;
  logic                  load_valid;
  logic [31:0]           load_data;
  logic                  load_last;
  logic                  load_ready;
  logic [ADDR_WIDTH:0]   word_count;
  logic                  fault;

  modport slave (
    input  ce, addr, load_start, load_valid, load_data, load_last,
    output inst, hold, load_ready, word_count, fault
  );

  modport master (
    output ce, addr, load_start, load_valid, load_data, load_last,
    input  inst, hold, load_ready, word_count, fault
  );
endinterface

// File: rtl/inst_rom_loader_array.sv
// inst_rom_array: DEPTH x 32 instruction store.
//   clk   : write clock
//   we    : write enable, waddr/wdata : synchronous write port
//   raddr : asynchronous read address, rdata : read data (same cycle)
// No reset on the storage so it maps onto distributed RAM.
module inst_rom_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// inst_rom_loader: instruction store with a host download port and a
// combinational fetch port for the core.
//   clk, rst : core clock, asynchronous active-low reset
//   bus      : fetch (ce/addr/inst/hold), download (load_*), status
//              (word_count/fault)
//   state    : loader FSM state, exported for observation
// The FSM walks IDLE -> LOAD -> RUN. hold stalls the core outside RUN;
// fault is sticky until reset and flags misaligned/out-of-range fetches
// and downloads that run past the end of the store.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  inst_rom_loader_if.slave  bus,
  output ldr_state_t        state
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH + 1)'(1);

  // word_count doubles as the write pointer: both restart at zero together
  // and advance on every accepted word, so one register serves both. The
  // extra top bit lets it report DEPTH after an overflowing download
  // instead of wrapping.
  logic [ADDR_WIDTH:0] word_count;
  logic                fault;

  logic        load_ready;
  logic        beat;
  logic        wr_en;
  logic [29:0] word_idx;
  logic        under_base;
  logic        in_range;
  logic        bad_fetch;
  logic        fetch_ok;
  logic [31:0] rdata;

  assign load_ready = (state == LDR_LOAD);
  assign beat       = bus.load_valid & load_ready;
  // A restart pulse in the same cycle as a beat wins; the word is dropped.
  assign wr_en      = beat & ~bus.load_start;

  // Word offset from the base; BASE_ADDR is assumed word aligned.
  assign word_idx   = bus.addr[31:2] - BASE_ADDR[31:2];
  assign under_base = bus.addr < BASE_ADDR;
  assign in_range   = ~under_base && (word_idx[29:ADDR_WIDTH] == '0);
  assign bad_fetch  = addr_misaligned(bus.addr) | ~in_range;
  assign fetch_ok   = (state == LDR_RUN) & bus.ce & ~bad_fetch;

  inst_rom_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (wr_en),
    .waddr (word_count[ADDR_WIDTH-1:0]),
    .wdata (bus.load_data),
    .raddr (word_idx[ADDR_WIDTH-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LDR_IDLE;
      word_count <= '0;
      fault      <= 1'b0;
    end else begin
      if ((state == LDR_RUN) && bus.ce && bad_fetch) begin
        fault <= 1'b1;
      end
      case (state)
        LDR_IDLE: begin
          if (bus.load_start) begin
            state      <= LDR_LOAD;
            word_count <= '0;
          end
        end
        LDR_LOAD: begin
          if (bus.load_start) begin
            word_count <= '0;
          end else if (beat) begin
            word_count <= word_count + ONE;
            if (bus.load_last) begin
              state <= LDR_RUN;
            end else if (word_count == LAST_IDX) begin
              // Store is full and the host still has more: stop here.
              fault <= 1'b1;
              state <= LDR_RUN;
            end
          end
        end
        LDR_RUN: begin
          if (bus.load_start) begin
            state      <= LDR_LOAD;
            word_count <= '0;
          end
        end
        default: begin
          state <= LDR_IDLE;
        end
      endcase
    end
  end

  assign bus.inst       = fetch_ok ? rdata : NOP_INST;
  assign bus.hold       = (state != LDR_RUN);
  assign bus.load_ready = load_ready;
  assign bus.word_count = word_count;
  assign bus.fault      = fault;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: randomized downloads and fetches checked
// against a word-array reference model; fetch results flow through an
// expected queue drained by a monitor on the falling edge.
module tb_inst_rom_loader;
  import inst_rom_loader_pkg::*;

  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_rom_loader_if #(.ADDR_WIDTH(AW)) bus ();
  ldr_state_t dbg_state;

  inst_rom_loader #(
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic        probe = 1'b0;

  // ---------------- reference model ----------------
  logic [31:0] model_mem [0:DEPTH-1];
  int          model_wc      = 0;
  bit          model_fault   = 1'b0;
  bit          model_run     = 1'b0;
  bit          model_loading = 1'b0;

  function automatic logic [31:0] model_fetch(input bit c, input logic [31:0] a);
    if (!model_run || !c) return 32'h0;
    if (a[1:0] != 2'b00) return 32'h0;
    if (a >= 32'h0000_1000) return 32'h0;
    return model_mem[a >> 2];
  endfunction

  task automatic model_fetch_fault(input bit c, input logic [31:0] a);
    if (model_run && c && ((a[1:0] != 2'b00) || (a >= 32'h0000_1000)))
      model_fault = 1'b1;
  endtask

  task automatic model_reset();
    model_run     = 1'b0;
    model_loading = 1'b0;
    model_wc      = 0;
    model_fault   = 1'b0;
  endtask

  task automatic model_begin_load();
    model_run     = 1'b0;
    model_loading = 1'b1;
    model_wc      = 0;
  endtask

  task automatic model_beat(input logic [31:0] d, input bit last);
    model_mem[model_wc] = d;
    model_wc++;
    if (last || model_wc == DEPTH) begin
      if (!last) model_fault = 1'b1;
      model_run     = 1'b1;
      model_loading = 1'b0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_hold"},       32'(bus.hold),       32'(!model_run));
    check({tag, "_load_ready"}, 32'(bus.load_ready), 32'(model_loading));
    check({tag, "_word_count"}, 32'(bus.word_count), 32'(model_wc));
    check({tag, "_fault"},      32'(bus.fault),      32'(model_fault));
  endtask

  // Monitor: a fetch is presented while probe is high; the response is
  // combinational, so it is sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (probe) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL inst_no_expected: actual=%h expected=none", bus.inst);
      end else begin
        check("inst", bus.inst, exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  // All drivers start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.ce   = 1'b1;
    bus.addr = 32'h8;
    rst      = 1'b0;
    #1;
    model_reset();
    check_status("rst");
    check("rst_inst", bus.inst, 32'h0);
    bus.ce = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic start_load();
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    model_begin_load();
  endtask

  task automatic send_beat(input logic [31:0] d, input bit last);
    bit got = 1'b0;
    int waited = 0;
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    while (!got && waited < 20) begin
      #3;
      if (bus.load_ready) got = 1'b1;
      @(posedge clk);
      #1;
      waited++;
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    if (got) begin
      model_beat(d, last);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_timeout: actual=load_ready low for %0d cycles expected=accept", waited);
    end
  endtask

  task automatic fetch(input bit c, input logic [31:0] a);
    bus.ce   = c;
    bus.addr = a;
    exp_q.push_back(model_fetch(c, a));
    probe = 1'b1;
    step();
    probe  = 1'b0;
    bus.ce = 1'b0;
    model_fetch_fault(c, a);
  endtask

  // allow_bad mixes in misaligned and out-of-range addresses.
  task automatic rand_fetch(input bit allow_bad);
    int r;
    int hi;
    logic [31:0] a;
    bit c;
    r  = allow_bad ? $urandom_range(0, 9) : 0;
    hi = (model_wc > 0) ? model_wc - 1 : 0;
    c  = ($urandom_range(0, 4) != 0);
    if (r == 7)      a = (32'($urandom_range(0, hi)) << 2) | 32'($urandom_range(1, 3));
    else if (r == 8) a = 32'h0000_1000 + (32'($urandom_range(0, 255)) << 2);
    else if (r == 9) a = $urandom | 32'h8000_0000;
    else             a = 32'($urandom_range(0, hi)) << 2;
    fetch(c, a);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] d;
    int n;
    bus.ce = 1'b0; bus.addr = 32'h0;
    bus.load_start = 1'b0; bus.load_valid = 1'b0;
    bus.load_data = 32'h0; bus.load_last = 1'b0;
    #2;

    // Basic four-word download and same-cycle fetch.
    do_reset();
    start_load();
    check_status("load_start");
    send_beat(32'h3401_0011, 1'b0);
    send_beat(32'h3402_0022, 1'b0);
    send_beat(32'h3403_0033, 1'b0);
    check_status("before_last");
    send_beat(32'h3404_0044, 1'b1);
    check_status("after_last");
    fetch(1'b1, 32'h8);
    fetch(1'b0, 32'h0);
    check_status("ce_low");
    for (int i = 0; i < 8; i++) rand_fetch(1'b0);

    // Misaligned fetch: NOP now, fault on the next edge, then sticky.
    check_status("pre_misalign");
    fetch(1'b1, 32'h2);
    check_status("post_misalign");
    for (int i = 0; i < 10; i++) fetch(1'b1, 32'($urandom_range(0, 3)) << 2);
    check_status("fault_sticky");

    // Overflow: fill the whole store without load_last.
    do_reset();
    start_load();
    for (int i = 0; i < DEPTH; i++) send_beat($urandom, 1'b0);
    check_status("overflow");
    check("overflow_state", 32'(dbg_state), 32'(LDR_RUN));
    fetch(1'b1, 32'h0000_0FFC);
    fetch(1'b1, 32'h0000_1000);
    for (int i = 0; i < 16; i++) rand_fetch(1'b1);
    // Host words in RUN are refused.
    bus.load_valid = 1'b1; bus.load_data = 32'h1234_5678;
    #2;
    check("run_ready", 32'(bus.load_ready), 32'h0);
    step();
    bus.load_valid = 1'b0;
    check_status("run_ignored");

    // Reset in the middle of a download.
    do_reset();
    start_load();
    send_beat($urandom, 1'b0);
    send_beat($urandom, 1'b0);
    bus.load_valid = 1'b1; bus.load_data = $urandom;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_status("mid_load_rst");
    bus.load_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    step();
    start_load();
    send_beat(32'hDEAD_BEEF, 1'b1);
    check_status("after_reload");
    fetch(1'b1, 32'h0);
    fetch(1'b1, 32'h4);

    // load_start while running, with a host word on the same cycle.
    bus.load_start = 1'b1;
    bus.load_valid = 1'b1; bus.load_data = 32'hBAD0_0001;
    #2;
    check("restart_ready", 32'(bus.load_ready), 32'h0);
    step();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    model_begin_load();
    check_status("restart_from_run");
    fetch(1'b1, 32'h0);
    // Restart pulse inside LOAD discards that cycle's word.
    send_beat($urandom, 1'b0);
    bus.load_start = 1'b1;
    bus.load_valid = 1'b1; bus.load_data = 32'hBAD0_0002;
    step();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    model_begin_load();
    check_status("restart_in_load");
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) send_beat($urandom, (i == n - 1));
    check_status("restart_done");
    for (int i = 0; i < 10; i++) rand_fetch(1'b0);

    // Random downloads of varying length with idle gaps and mixed fetches.
    for (int k = 0; k < 3; k++) begin
      start_load();
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 1)) step();
        d = $urandom;
        send_beat(d, (i == n - 1));
      end
      check_status("rand_load");
      for (int i = 0; i < 24; i++) rand_fetch(1'b1);
      check_status("rand_fetch");
    end

    step();
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so a stuck handshake cannot hang the run.
  initial begin
    #2000000;
    $display("FAIL watchdog: actual=time limit reached expected=test complete");
    $fatal(1, "watchdog expired");
  end

endmodule
